// File: rtl/reg_dump_reader_if.sv
// Output stream of the register dump reader: one {address, data} word per
// valid/ready handshake.
interface reg_dump_reader_if #(
    parameter int unsigned REG_SIZE = 32,
    parameter int unsigned REGW     = 5
);
    logic                valid_o;
    logic                ready_i;
    logic [REGW-1:0]     addr_o;
    logic [REG_SIZE-1:0] data_o;

    modport master (output valid_o, output addr_o, output data_o, input ready_i);
    modport slave  (input valid_o, input addr_o, input data_o, output ready_i);
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a wrapping range of register addresses through one combinational
// register-file read port and streams {address, data} words downstream.
module reg_dump_reader #(
    parameter int unsigned REG_SIZE   = 32,
    parameter int unsigned NO_OF_REGS = 32,
    parameter int unsigned REGW       = $clog2(NO_OF_REGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [REGW-1:0]     first_i,
    input  logic [REGW-1:0]     last_i,
    output logic [REGW-1:0]     raddr_o,
    input  logic [REG_SIZE-1:0] rdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    reg_dump_reader_if.master   out_if
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [REGW-1:0] TOP_IDX = REGW'(NO_OF_REGS - 1);

    state_t              state_q;
    logic [REGW-1:0]     ptr_q;
    logic [REGW-1:0]     last_q;
    logic [REGW-1:0]     addr_q;
    logic [REG_SIZE-1:0] data_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [REGW-1:0]     ptr_d;
    logic                at_last;
    logic                handshake;
    logic                advance;
    logic                range_bad;

    // Wrapping increment and the read-address steering for back-to-back words.
    always_comb begin
        ptr_d     = (ptr_q == TOP_IDX) ? '0 : ptr_q + REGW'(1);
        at_last   = (ptr_q == last_q);
        handshake = (state_q == S_SEND) && out_if.ready_i && !abort_i;
        advance   = handshake && !at_last;
        raddr_o   = advance ? ptr_d : ptr_q;
        range_bad = (32'(first_i) >= NO_OF_REGS) || (32'(last_i) >= NO_OF_REGS);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        if (range_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            ptr_q   <= first_i;
                            last_q  <= last_i;
                            busy_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (abort_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        addr_q  <= ptr_q;
                        data_q  <= rdata_i;
                        valid_q <= 1'b1;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Abort wins over a same-cycle handshake: the word is dropped.
                    if (abort_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (handshake) begin
                        if (at_last) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            ptr_q  <= ptr_d;
                            addr_q <= ptr_d;
                            data_q <= rdata_i;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_if.valid_o = valid_q;
    assign out_if.addr_o  = addr_q;
    assign out_if.data_o  = data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected words are queued at start
// from a register-array model; a negedge monitor pops and compares them.
module tb_reg_dump_reader;

    localparam int unsigned N   = 32;
    localparam int unsigned N24 = 24;
    localparam int unsigned W   = 5;

    typedef struct packed {
        logic [W-1:0] a;
        logic [31:0]  d;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start, abort;
    logic [W-1:0] first, last, raddr;
    logic [31:0]  rdata;
    logic         busy, done, err;

    logic         start24;
    logic [W-1:0] first24, last24, raddr24;
    logic [31:0]  rdata24;
    logic         busy24, done24, err24;

    logic [31:0] regs [N];

    reg_dump_reader_if #(.REG_SIZE(32), .REGW(W)) ifc ();
    reg_dump_reader_if #(.REG_SIZE(32), .REGW(W)) ifc24 ();

    assign rdata   = regs[raddr];
    assign rdata24 = regs[raddr24];

    reg_dump_reader #(.REG_SIZE(32), .NO_OF_REGS(N), .REGW(W)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .abort_i(abort),
        .first_i(first), .last_i(last), .raddr_o(raddr), .rdata_i(rdata),
        .busy_o(busy), .done_o(done), .err_o(err), .out_if(ifc.master)
    );

    reg_dump_reader #(.REG_SIZE(32), .NO_OF_REGS(N24), .REGW(W)) dut24 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start24), .abort_i(1'b0),
        .first_i(first24), .last_i(last24), .raddr_o(raddr24), .rdata_i(rdata24),
        .busy_o(busy24), .done_o(done24), .err_o(err24), .out_if(ifc24.master)
    );

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    start_cyc = 0;
    int    done_cyc = -1;
    int    exp_done_cyc = -1;
    int    ready_mode = 0;
    bit    done_seen = 0;
    bit    chk_latency = 0;
    word_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Ready driver: always, 1-0-0 pattern, or random.
    initial begin
        int phase = 0;
        ifc.ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ifc.ready_i = 1'b1;
                1:       ifc.ready_i = (phase % 3 == 0);
                default: ifc.ready_i = 1'($urandom_range(0, 1));
            endcase
            phase++;
        end
    end

    // Monitor: compares presented words against the queue head, pops on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.valid_o && chk_latency) begin
                chk_latency = 0;
                check("first_latency", 64'(cyc), 64'(start_cyc + 2));
            end
            if (ifc.valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(ifc.addr_o), 64'hdead);
                end else begin
                    check("addr", 64'(ifc.addr_o), 64'(exp_q[0].a));
                    check("data", 64'(ifc.data_o), 64'(exp_q[0].d));
                    check("busy_in_send", 64'(busy), 64'(1));
                    if (ifc.ready_i && !abort) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                        if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
                    end
                end
            end
            if (done || cyc == exp_done_cyc) begin
                check("done_pulse", 64'(done), 64'(cyc == exp_done_cyc));
                if (done) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                end
            end
            if (err) check("err_unexpected", 64'(err), 64'(0));
        end
    end

    task automatic randomize_regs();
        for (int i = 0; i < int'(N); i++) regs[i] = $urandom;
    endtask

    task automatic start_dump(input int f, input int l);
        int k;
        @(posedge clk);
        #1;
        first = W'(f);
        last  = W'(l);
        start = 1'b1;
        start_cyc   = cyc;
        chk_latency = 1;
        done_seen   = 0;
        k = ((l - f) % int'(N) + int'(N)) % int'(N) + 1;
        for (int i = 0; i < k; i++) begin
            int a = (f + i) % int'(N);
            exp_q.push_back('{a: W'(a), d: regs[a]});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int c = 0; c < bound && !done_seen; c++) @(posedge clk);
        @(negedge clk);
        #1;
        check("done_seen", 64'(done_seen), 64'(1));
        check("words_left", 64'(exp_q.size()), 64'(0));
        check("busy_after", 64'(busy), 64'(0));
        check("valid_after", 64'(ifc.valid_o), 64'(0));
    endtask

    initial begin
        int hs0;
        int exp24 [4];
        int idx;
        int d24;
        bit corrupted;

        rst_n = 1'b0;
        start = 0; abort = 0; first = '0; last = '0;
        start24 = 0; first24 = '0; last24 = '0;
        ifc24.ready_i = 1'b1;
        for (int i = 0; i < int'(N); i++) regs[i] = 32'(i * 3 + 1);
        #1;
        check("rst_valid", 64'(ifc.valid_o), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_addr", 64'(ifc.addr_o), 64'(0));
        check("rst_data", 64'(ifc.data_o), 64'(0));
        check("rst_raddr", 64'(raddr), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic four-word dump under continuous ready.
        regs[1] = 5; regs[2] = 8; regs[3] = 19; regs[4] = 20;
        ready_mode = 0;
        hs0 = hs_count;
        start_dump(1, 4);
        wait_done(20);
        check("done_latency", 64'(done_cyc), 64'(start_cyc + 4 + 2));
        check("hs_basic", 64'(hs_count - hs0), 64'(4));

        // Same dump with a stalling consumer; the held word's register is
        // rewritten mid-stall and must not leak into the captured snapshot.
        ready_mode = 1;
        hs0 = hs_count;
        corrupted = 0;
        start_dump(1, 4);
        for (int c = 0; c < 60 && !done_seen; c++) begin
            @(negedge clk);
            #1;
            if (!corrupted && ifc.valid_o && !ifc.ready_i) begin
                regs[ifc.addr_o] = regs[ifc.addr_o] + 32'd1;
                corrupted = 1;
            end
        end
        wait_done(20);
        check("hs_stall", 64'(hs_count - hs0), 64'(4));

        // Wrap through the top of the file.
        ready_mode = 0;
        regs[30] = 32'hA; regs[31] = 32'hB; regs[0] = 0; regs[1] = 32'hC;
        start_dump(30, 1);
        wait_done(20);

        // Single-word range.
        hs0 = hs_count;
        start_dump(7, 7);
        wait_done(20);
        check("hs_single", 64'(hs_count - hs0), 64'(1));

        // Out-of-range start on a 24-entry file.
        @(posedge clk); #1;
        start24 = 1; first24 = W'(25); last24 = W'(3);
        @(posedge clk); #1;
        start24 = 0;
        @(negedge clk);
        check("err24_pulse", 64'(err24), 64'(1));
        @(negedge clk);
        check("err24_single", 64'(err24), 64'(0));
        check("busy24_idle", 64'(busy24), 64'(0));
        check("valid24_idle", 64'(ifc24.valid_o), 64'(0));
        @(posedge clk); #1;
        start24 = 1; first24 = W'(3); last24 = W'(24);
        @(posedge clk); #1;
        start24 = 0;
        @(negedge clk);
        check("err24_last", 64'(err24), 64'(1));
        @(negedge clk);
        check("busy24_idle2", 64'(busy24), 64'(0));

        // Valid wrapping dump on the 24-entry file: 22, 23, 0, 1.
        exp24 = '{22, 23, 0, 1};
        idx = 0;
        d24 = 0;
        randomize_regs();
        @(posedge clk); #1;
        start24 = 1; first24 = W'(22); last24 = W'(1);
        @(posedge clk); #1;
        start24 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done24) d24++;
            if (ifc24.valid_o) begin
                if (idx < 4) begin
                    check("w24_addr", 64'(ifc24.addr_o), 64'(exp24[idx]));
                    check("w24_data", 64'(ifc24.data_o), 64'(regs[exp24[idx]]));
                end
                idx++;
            end
        end
        check("w24_count", 64'(idx), 64'(4));
        check("w24_done", 64'(d24), 64'(1));

        // Abort while the second word is on the bus.
        randomize_regs();
        hs0 = hs_count;
        start_dump(0, 9);
        for (int c = 0; c < 20 && hs_count < hs0 + 1; c++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk); #1;
        abort = 1;
        @(negedge clk); #1;
        exp_q.delete();
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        check("abort_valid", 64'(ifc.valid_o), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hs", 64'(hs_count - hs0), 64'(1));
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_seen), 64'(0));
        start_dump(10, 9);
        wait_done(80);

        // Abort together with start in IDLE does nothing.
        @(posedge clk); #1;
        start = 1; abort = 1; first = W'(2); last = W'(3);
        @(posedge clk); #1;
        start = 0; abort = 0;
        repeat (3) @(negedge clk);
        check("abort_idle_busy", 64'(busy), 64'(0));
        check("abort_idle_valid", 64'(ifc.valid_o), 64'(0));

        // Asynchronous reset mid-dump.
        hs0 = hs_count;
        start_dump(0, 15);
        for (int c = 0; c < 20 && hs_count < hs0 + 3; c++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 64'(ifc.valid_o), 64'(0));
        check("rstmid_busy", 64'(busy), 64'(0));
        check("rstmid_addr", 64'(ifc.addr_o), 64'(0));
        exp_q.delete();
        exp_done_cyc = -1;
        done_seen = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_no_done", 64'(done_seen), 64'(0));
        randomize_regs();
        start_dump(3, 2);
        wait_done(80);

        // Random ranges under random back-pressure, with ignored mid-dump starts.
        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            randomize_regs();
            start_dump(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
            @(posedge clk); #1;
            if (busy) begin
                first = W'($urandom_range(0, N - 1));
                last  = W'($urandom_range(0, N - 1));
                start = 1;
                @(posedge clk); #1;
                start = 0;
            end
            wait_done(300);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
